ddr_block_fetcher: RTL and testbench

- Read-side counterpart of the write-back accumulator.
- Pulls a rectangular region of 32-bit elements from DDR3 through the Avalon-MM master port.
- Reassembles the region into 8x8-element blocks in raster block order.
- Presents each block, with its block number, to the ALU over a valid/ready handshake; the ALU's block/block_num inputs then feed the accumulator.

---
 rtl/ddr_block_fetcher_pkg.sv | 32 +++
 rtl/ddr_block_fetcher_if.sv | 45 ++++
 rtl/ddr_block_fetcher_addr_gen.sv | 101 ++++++++++
 rtl/ddr_block_fetcher.sv | 142 ++++++++++++++
 tb/tb_ddr_block_fetcher.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_block_fetcher_pkg.sv
// ddr_block_fetcher shared types and constants.
// Block geometry, Avalon widths, FSM states.
package fetch_pkg;

  localparam int BLOCK_WIDTH = 8;
  localparam int BLOCK_SIZE = BLOCK_WIDTH * BLOCK_WIDTH;
  localparam int AVL_ADDR_W = 26;
  localparam int AVL_DATA_W = 128;
  localparam int LANES = AVL_DATA_W / 32;
  localparam int WORDS_PER_BROW = BLOCK_WIDTH * 32 / AVL_DATA_W;
  localparam int WORDS_PER_BLOCK = BLOCK_WIDTH * WORDS_PER_BROW;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    PRESENT,
    DONE
  } state_t;

  typedef logic [BLOCK_SIZE-1:0][31:0] block_t;
  typedef logic [AVL_ADDR_W-1:0] addr_t;

  // Element slot for a lane of the word at wcnt: r*8 + w*4 + lane.
  function automatic logic [5:0] elem_idx(
    input logic [3:0] wcnt,
    input logic [1:0] lane
  );
    return {wcnt, lane};
  endfunction

endpackage

// File: rtl/ddr_block_fetcher_if.sv
// ddr_block_fetcher bus bundle.
// Avalon-MM read master plus block stream to the ALU.
interface ddr_block_fetcher_if;

  logic                                local_init_done;
  fetch_pkg::addr_t                    avl_address;
  logic                                avl_read;
  logic                                avl_burstbegin;
  logic                                avl_wait_request_n;
  logic [fetch_pkg::AVL_DATA_W-1:0]    avl_readdata;
  logic                                avl_readdatavalid;
  logic                                block_valid;
  logic                                block_ready;
  fetch_pkg::block_t                   block;
  logic [15:0]                         block_num;

  modport master (
    input  local_init_done,
    input  avl_wait_request_n,
    input  avl_readdata,
    input  avl_readdatavalid,
    input  block_ready,
    output avl_address,
    output avl_read,
    output avl_burstbegin,
    output block_valid,
    output block,
    output block_num
  );

  modport slave (
    output local_init_done,
    output avl_wait_request_n,
    output avl_readdata,
    output avl_readdatavalid,
    output block_ready,
    input  avl_address,
    input  avl_read,
    input  avl_burstbegin,
    input  block_valid,
    input  block,
    input  block_num
  );

endinterface

// File: rtl/ddr_block_fetcher_addr_gen.sv
// block_addr_gen: block/row/word walk over the region.
// Address is built from running bases, no multiplier.
module block_addr_gen
  import fetch_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        i_load,
  input  logic        i_word_adv,
  input  logic        i_block_adv,
  input  addr_t       i_start_address,
  input  logic [15:0] i_stride,
  input  logic [15:0] i_block_rows,
  input  logic [15:0] i_block_cols,
  output addr_t       o_addr,
  output logic [3:0]  o_wcnt,
  output logic        o_last_word,
  output logic        o_last_block,
  output logic [15:0] o_block_num
);

  logic [15:0] r_stride;
  logic [15:0] r_rows;
  logic [15:0] r_cols;
  logic [15:0] r_br;
  logic [15:0] r_bc;
  logic [15:0] r_block_num;
  logic [3:0]  r_wcnt;
  addr_t       r_blk_base;
  addr_t       r_row_base;
  addr_t       r_col_off;

  addr_t       w_stride;
  addr_t       w_stride8;
  addr_t       w_next_blk;
  logic        w_last_bc;

  assign w_stride   = addr_t'(r_stride);
  assign w_stride8  = w_stride << 3;
  assign w_next_blk = r_blk_base + w_stride8;
  assign w_last_bc  = (r_bc == r_cols - 16'd1);

  assign o_addr       = r_row_base + r_col_off
                      + addr_t'(r_wcnt[0]);
  assign o_wcnt       = r_wcnt;
  assign o_last_word  = (r_wcnt == 4'(WORDS_PER_BLOCK - 1));
  assign o_last_block = w_last_bc
                      && (r_br == r_rows - 16'd1);
  assign o_block_num  = r_block_num;

  // Config latch and the br/bc/wcnt walk with base accumulators.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_stride    <= '0;
      r_rows      <= '0;
      r_cols      <= '0;
      r_br        <= '0;
      r_bc        <= '0;
      r_block_num <= '0;
      r_wcnt      <= '0;
      r_blk_base  <= '0;
      r_row_base  <= '0;
      r_col_off   <= '0;
    end else if (i_load) begin
      r_stride    <= i_stride;
      r_rows      <= i_block_rows;
      r_cols      <= i_block_cols;
      r_br        <= '0;
      r_bc        <= '0;
      r_block_num <= '0;
      r_wcnt      <= '0;
      r_blk_base  <= i_start_address;
      r_row_base  <= i_start_address;
      r_col_off   <= '0;
    end else if (i_block_adv) begin
      r_block_num <= r_block_num + 16'd1;
      r_wcnt      <= '0;
      if (w_last_bc) begin
        r_bc       <= '0;
        r_br       <= r_br + 16'd1;
        r_col_off  <= '0;
        r_blk_base <= w_next_blk;
        r_row_base <= w_next_blk;
      end else begin
        r_bc       <= r_bc + 16'd1;
        r_col_off  <= r_col_off
                    + addr_t'(WORDS_PER_BROW);
        r_row_base <= r_blk_base;
      end
    end else if (i_word_adv) begin
      if (o_last_word) begin
        r_wcnt <= '0;
      end else begin
        r_wcnt <= r_wcnt + 4'd1;
        if (r_wcnt[0])
          r_row_base <= r_row_base + w_stride;
      end
    end
  end

endmodule

// File: rtl/ddr_block_fetcher.sv
// ddr_block_fetcher: DDR3 region to 8x8 block stream.
// One read in flight; blocks handed out in raster order.
module ddr_block_fetcher
  import fetch_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        start,
  input  addr_t       start_address,
  input  logic [15:0] stride,
  input  logic [15:0] block_rows,
  input  logic [15:0] block_cols,
  output logic        busy,
  output logic        done,
  ddr_block_fetcher_if.master bus
);

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_avl_read;
  logic        r_block_valid;
  block_t      r_block;

  addr_t       w_addr;
  logic [3:0]  w_wcnt;
  logic        w_last_word;
  logic        w_last_block;
  logic [15:0] w_block_num;
  logic        w_load;
  logic        w_word_adv;
  logic        w_block_adv;
  logic        w_zero_dims;

  assign w_zero_dims = (block_rows == 16'd0)
                    || (block_cols == 16'd0);
  assign w_load      = (r_state == IDLE) && start
                    && bus.local_init_done;
  assign w_word_adv  = (r_state == WAIT_DATA)
                    && bus.avl_readdatavalid;
  assign w_block_adv = (r_state == PRESENT)
                    && r_block_valid && bus.block_ready;

  block_addr_gen u_addr_gen (
    .iCLK            (iCLK),
    .iRST            (iRST),
    .i_load          (w_load),
    .i_word_adv      (w_word_adv),
    .i_block_adv     (w_block_adv),
    .i_start_address (start_address),
    .i_stride        (stride),
    .i_block_rows    (block_rows),
    .i_block_cols    (block_cols),
    .o_addr          (w_addr),
    .o_wcnt          (w_wcnt),
    .o_last_word     (w_last_word),
    .o_last_block    (w_last_block),
    .o_block_num     (w_block_num)
  );

  assign busy               = r_busy;
  assign done               = r_done;
  assign bus.avl_address    = w_addr;
  assign bus.avl_read       = r_avl_read;
  assign bus.avl_burstbegin = r_avl_read;
  assign bus.block_valid    = r_block_valid;
  assign bus.block          = r_block;
  assign bus.block_num      = w_block_num;

  // Fetch sequencer: issue, wait data, present, done.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state       <= IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_avl_read    <= 1'b0;
      r_block_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_load) begin
            r_busy <= 1'b1;
            if (w_zero_dims) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_avl_read <= 1'b1;
              r_state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.avl_wait_request_n) begin
            r_avl_read <= 1'b0;
            r_state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (bus.avl_readdatavalid) begin
            if (w_last_word) begin
              r_block_valid <= 1'b1;
              r_state       <= PRESENT;
            end else begin
              r_avl_read <= 1'b1;
              r_state    <= ISSUE;
            end
          end
        end
        PRESENT: begin
          if (w_block_adv) begin
            r_block_valid <= 1'b0;
            if (w_last_block) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_avl_read <= 1'b1;
              r_state    <= ISSUE;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Scatter each returned word's lanes into the block register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_block <= '0;
    end else if (w_word_adv) begin
      for (int l = 0; l < LANES; l++)
        r_block[elem_idx(w_wcnt, 2'(l))] <=
          bus.avl_readdata[32*l +: 32];
    end
  end

endmodule

// File: tb/tb_ddr_block_fetcher.sv
// tb_ddr_block_fetcher: randomized bench with DDR and ALU models.
// Expected blocks/addresses come from a region-level reference.
module tb_ddr_block_fetcher;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  addr_t       start_address;
  logic [15:0] stride;
  logic [15:0] block_rows;
  logic [15:0] block_cols;
  logic        busy;
  logic        done;

  int          errors = 0;
  int          checks = 0;

  addr_t       acc_q[$];
  int          acc_cnt = 0;
  int          stall_pct = 0;
  int          lat_max = 0;
  int          stall_at = -1;
  int          stall_left = 0;
  logic        obs_read[$];
  addr_t       obs_addr[$];
  bit          stray_req = 1'b0;
  bit          pend_valid = 1'b0;
  int          pend_cnt = 0;
  addr_t       pend_addr = '0;
  logic [15:0] num_q[$];
  block_t      blk_q[$];

  ddr_block_fetcher_if bus();

  ddr_block_fetcher dut (
    .iCLK          (clk),
    .iRST          (rst),
    .start         (start),
    .start_address (start_address),
    .stride        (stride),
    .block_rows    (block_rows),
    .block_cols    (block_cols),
    .busy          (busy),
    .done          (done),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Address of word k (0..15) of raster block b, wrapped to 26 bits.
  function automatic addr_t model_addr(
    input addr_t sa, input int st, input int cols,
    input int b, input int k
  );
    longint br, bc, a;
    br = longint'(b / cols);
    bc = longint'(b % cols);
    a = longint'(sa) + (br * 8 + longint'(k / 2)) * longint'(st)
      + bc * 2 + longint'(k % 2);
    return addr_t'(a);
  endfunction

  // Element e of block b: memory word value addr*4 + lane.
  function automatic logic [31:0] model_elem(
    input addr_t sa, input int st, input int cols,
    input int b, input int e
  );
    int r, c;
    addr_t a;
    r = e / 8;
    c = e % 8;
    a = model_addr(sa, st, cols, b, r * 2 + c / 4);
    return {4'b0, a, 2'b00} + 32'(c % 4);
  endfunction

  // DDR responder: random waitrequest, random read latency.
  initial begin
    bus.avl_wait_request_n = 1'b0;
    bus.avl_readdatavalid  = 1'b0;
    bus.avl_readdata       = '0;
    forever begin
      logic wrn;
      @(negedge clk);
      bus.avl_readdatavalid = 1'b0;
      if (stray_req) begin
        stray_req = 1'b0;
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata = {4{32'hDEAD_BEEF}};
      end else if (pend_valid) begin
        if (pend_cnt == 0) begin
          pend_valid = 1'b0;
          bus.avl_readdatavalid = 1'b1;
          for (int l = 0; l < 4; l++)
            bus.avl_readdata[32*l +: 32] =
              {4'b0, pend_addr, 2'b00} + 32'(l);
        end else begin
          pend_cnt--;
        end
      end
      wrn = 1'b1;
      if (bus.avl_read === 1'b1) begin
        if (stall_at == acc_cnt && stall_left > 0) begin
          wrn = 1'b0;
          stall_left--;
          obs_read.push_back(bus.avl_read);
          obs_addr.push_back(bus.avl_address);
        end else if (int'($urandom_range(99)) < stall_pct) begin
          wrn = 1'b0;
        end
      end
      bus.avl_wait_request_n = wrn;
      if (bus.avl_read === 1'b1 && wrn) begin
        acc_q.push_back(bus.avl_address);
        acc_cnt++;
        pend_valid = 1'b1;
        pend_cnt = int'($urandom_range(lat_max));
        pend_addr = bus.avl_address;
      end
    end
  end

  task automatic run_region(
    input addr_t sa, input int st, input int rows,
    input int cols, input int hold
  );
    int nblk, t, h;
    bit ok;
    block_t cap, want_blk;
    logic [15:0] cap_num;
    addr_t exp_a;
    nblk = rows * cols;
    acc_q.delete();
    acc_cnt = 0;
    num_q.delete();
    blk_q.delete();
    @(negedge clk);
    start_address = sa;
    stride = 16'(st);
    block_rows = 16'(rows);
    block_cols = 16'(cols);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    for (int b = 0; b < nblk; b++) begin
      t = 0;
      while (bus.block_valid !== 1'b1 && t < 4000) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (bus.block_valid !== 1'b1) begin
        errors++;
        $display("FAIL block_wait: block %0d not valid in 4000 cycles", b);
        return;
      end
      cap = bus.block;
      cap_num = bus.block_num;
      h = (hold < 0) ? int'($urandom_range(3)) : hold;
      ok = 1'b1;
      for (int k = 0; k < h; k++) begin
        @(negedge clk);
        if (bus.block_valid !== 1'b1 || bus.block !== cap ||
            bus.block_num !== cap_num || bus.avl_read !== 1'b0)
          ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL hold_stable: block %0d changed or read during %0d-cycle stall", b, h);
      end
      checks++;
      if (cap_num !== 16'(b)) begin
        errors++;
        $display("FAIL block_num: got %0d want %0d", cap_num, b);
      end
      for (int e = 0; e < 64; e++)
        want_blk[e] = model_elem(sa, st, cols, b, e);
      checks++;
      if (cap !== want_blk) begin
        errors++;
        for (int e = 0; e < 64; e++)
          if (cap[e] !== want_blk[e]) begin
            $display("FAIL block_data: blk %0d elem %0d got %h want %h",
                     b, e, cap[e], want_blk[e]);
            break;
          end
      end
      num_q.push_back(cap_num);
      blk_q.push_back(cap);
      bus.block_ready = 1'b1;
      @(negedge clk);
      bus.block_ready = 1'b0;
      if (b < nblk - 1) begin
        exp_a = model_addr(sa, st, cols, b + 1, 0);
        checks++;
        if (bus.avl_read !== 1'b1 || bus.avl_address !== exp_a) begin
          errors++;
          $display("FAIL next_issue: read=%b addr=%h want read=1 addr=%h",
                   bus.avl_read, bus.avl_address, exp_a);
        end
      end else begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL done_pulse: got %b want 1", done);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_end: done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (acc_q.size() != nblk * 16) begin
      errors++;
      $display("FAIL read_count: got %0d want %0d", acc_q.size(), nblk * 16);
    end
    ok = 1'b1;
    for (int i = 0; i < acc_q.size() && i < nblk * 16; i++)
      if (acc_q[i] !== model_addr(sa, st, cols, i / 16, i % 16)) begin
        if (ok)
          $display("FAIL addr_seq: read %0d got %h want %h", i, acc_q[i],
                   model_addr(sa, st, cols, i / 16, i % 16));
        ok = 1'b0;
      end
    checks++;
    if (!ok) errors++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start_address = '0;
    stride = '0;
    block_rows = '0;
    block_cols = '0;
    bus.block_ready = 1'b0;
    bus.local_init_done = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_status: busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (bus.avl_read !== 1'b0 || bus.avl_burstbegin !== 1'b0) begin
      errors++;
      $display("FAIL rst_avl: read=%b bb=%b want 0 0", bus.avl_read, bus.avl_burstbegin);
    end
    checks++;
    if (bus.avl_address !== '0) begin
      errors++;
      $display("FAIL rst_addr: got %h want 0", bus.avl_address);
    end
    checks++;
    if (bus.block_valid !== 1'b0 || bus.block_num !== 16'd0) begin
      errors++;
      $display("FAIL rst_blk: valid=%b num=%0d want 0 0", bus.block_valid, bus.block_num);
    end
    checks++;
    if (bus.block !== '0) begin
      errors++;
      $display("FAIL rst_block: got nonzero want 0");
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    block_t bb;
    stall_pct = 0;
    lat_max = 0;
    run_region(26'h100, 4, 1, 1, 0);
    checks++;
    if (acc_q.size() != 16 || acc_q[0] !== 26'h100 || acc_q[1] !== 26'h101 ||
        acc_q[2] !== 26'h104 || acc_q[14] !== 26'h11C ||
        acc_q[15] !== 26'h11D) begin
      errors++;
      $display("FAIL single_addrs: n=%0d first=%h want 16 reads 0x100..0x11D",
               acc_q.size(), acc_q.size() > 0 ? acc_q[0] : '0);
    end
    bb = (blk_q.size() > 0) ? blk_q[0] : '0;
    checks++;
    if (bb[0] !== 32'h400 || bb[8] !== 32'h410 || bb[63] !== 32'h477) begin
      errors++;
      $display("FAIL single_elems: %h %h %h want 400 410 477", bb[0], bb[8], bb[63]);
    end
  endtask

  task automatic test_2x2();
    block_t bb;
    stall_pct = 20;
    lat_max = 2;
    run_region(26'h0, 4, 2, 2, -1);
    checks++;
    if (num_q.size() != 4 || num_q[0] !== 16'd0 || num_q[1] !== 16'd1 ||
        num_q[2] !== 16'd2 || num_q[3] !== 16'd3) begin
      errors++;
      $display("FAIL blocknum_seq: n=%0d want 0,1,2,3", num_q.size());
    end
    checks++;
    if (acc_q.size() != 64 || acc_q[48] !== 26'h22) begin
      errors++;
      $display("FAIL blk3_first_addr: got %h want 22",
               acc_q.size() > 48 ? acc_q[48] : '0);
    end
    bb = (blk_q.size() > 1) ? blk_q[1] : '0;
    checks++;
    if (bb[0] !== 32'h8) begin
      errors++;
      $display("FAIL blk1_elem0: got %h want 8", bb[0]);
    end
  endtask

  task automatic test_stall();
    bit ok;
    stall_pct = 0;
    lat_max = 1;
    obs_read.delete();
    obs_addr.delete();
    stall_at = 2;
    stall_left = 5;
    run_region(26'h100, 4, 1, 1, 0);
    stall_at = -1;
    ok = (obs_read.size() == 5);
    foreach (obs_read[i])
      if (obs_read[i] !== 1'b1 || obs_addr[i] !== 26'h104) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_hold: %0d stalled cycles, want 5 with read=1 addr=104",
               obs_read.size());
    end
    checks++;
    if (acc_q.size() != 16 || acc_q[2] !== 26'h104 || acc_q[3] !== 26'h105) begin
      errors++;
      $display("FAIL stall_accept: n=%0d want one acceptance of 104", acc_q.size());
    end
  endtask

  task automatic test_backpressure();
    stall_pct = 10;
    lat_max = 1;
    run_region(26'h300, 2, 1, 2, 10);
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    stall_pct = 0;
    lat_max = 1;
    acc_q.delete();
    acc_cnt = 0;
    @(negedge clk);
    start_address = 26'h200;
    stride = 16'd8;
    block_rows = 16'd1;
    block_cols = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (acc_cnt < 7 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (acc_cnt < 7) begin
      errors++;
      $display("FAIL rst_mid_wait: got %0d acceptances want 7", acc_cnt);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.avl_read !== 1'b0 ||
        bus.block_valid !== 1'b0 || bus.block_num !== 16'd0 ||
        bus.avl_address !== '0 || bus.block !== '0) begin
      errors++;
      $display("FAIL rst_mid_outs: busy=%b read=%b valid=%b addr=%h want all 0",
               busy, bus.avl_read, bus.block_valid, bus.avl_address);
    end
    @(negedge clk);
    rst = 1'b0;
    stray_req = 1'b1;
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.block_valid !== 1'b0 || bus.avl_read !== 1'b0 || busy !== 1'b0)
        ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_stray: activity after reset, want idle");
    end
    run_region(26'h40, 16, 1, 1, -1);
  endtask

  task automatic test_zero_and_gating();
    int reads;
    @(negedge clk);
    start_address = 26'h10;
    stride = 16'd4;
    block_rows = 16'd0;
    block_cols = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b want 1 1", done, busy);
    end
    reads = (bus.avl_read === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.avl_read !== 1'b0) reads++;
    end
    checks++;
    if (reads != 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_reads: reads=%0d busy=%b want 0 0", reads, busy);
    end
    block_rows = 16'd2;
    block_cols = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || bus.avl_read !== 1'b0) begin
      errors++;
      $display("FAIL zero_cols: done=%b read=%b want 1 0", done, bus.avl_read);
    end
    repeat (2) @(negedge clk);
    bus.local_init_done = 1'b0;
    block_rows = 16'd1;
    block_cols = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reads = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.avl_read !== 1'b0 || busy !== 1'b0) reads++;
    end
    checks++;
    if (busy !== 1'b0 || reads != 0) begin
      errors++;
      $display("FAIL init_gate: busy=%b active=%0d want 0 0", busy, reads);
    end
    bus.local_init_done = 1'b1;
  endtask

  task automatic test_wrap();
    stall_pct = 15;
    lat_max = 2;
    run_region(26'h3FF_FFF8, 16'hFFFF, 2, 2, -1);
  endtask

  task automatic test_random();
    addr_t sa;
    int st, rows, cols;
    stall_pct = 25;
    lat_max = 3;
    for (int n = 0; n < 4; n++) begin
      sa = addr_t'($urandom);
      st = int'($urandom_range(600, 1));
      rows = int'($urandom_range(2, 1));
      cols = int'($urandom_range(3, 1));
      run_region(sa, st, rows, cols, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_2x2();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_zero_and_gating();
    test_wrap();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
